// File: rtl/decode_pkg.sv
// Shared CPU package for the decode stage.
// Holds the opcode-class enum, the immediate-format enum, the RV32I major
// opcode constants, the bubble instruction word and the pipeline bundle
// type carried in the decode/execute register.
package decode_pkg;

  // Opcode classes reported to execute.
  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_FENCE   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_ILLEGAL = 4'd11
  } op_t;

  // Immediate layouts; IMM_NONE yields zero.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Contents of the decode/execute pipeline register.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        we;
    logic        illegal;
  } dec_bundle_t;

  // Classes that write a destination register (before the rd != 0 check).
  function automatic logic op_writes_rd(input op_t op);
    logic w;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_OPIMM, OP_OP: w = 1'b1;
      default:                  w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// imm_gen: combinational immediate extraction.
// Ports:
//   instr - raw 32-bit instruction word
//   fmt   - immediate layout selected by the decoder
//   imm   - sign-extended byte-offset immediate (zero for IMM_NONE)
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate bits; instr[31] is always the sign.
  always_comb begin
    imm = 32'h0000_0000;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/decode.sv
// decode: RV32I decode stage, one pipeline register deep.
// Decodes fetch_dec_* combinationally and registers the result, so every
// output is valid one cycle after the instruction is presented.
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   fetch_dec_instr   - instruction word from fetch
//   fetch_dec_pc      - word-addressed PC+1 from fetch
//   fetch_dec_valid   - fetch carries a real instruction
//   stall             - hold the output register
//   flush             - replace the output register with a bubble
//   dec_ex_*          - registered decoded bundle for execute
module decode
  import decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_dec_instr,
  input  logic [31:0] fetch_dec_pc,
  input  logic        fetch_dec_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        dec_ex_valid,
  output logic [31:0] dec_ex_instr,
  output logic [31:0] dec_ex_pc,
  output op_t         dec_ex_op,
  output logic [4:0]  dec_ex_rd,
  output logic [4:0]  dec_ex_rs1,
  output logic [4:0]  dec_ex_rs2,
  output logic [2:0]  dec_ex_funct3,
  output logic        dec_ex_funct7b5,
  output logic [31:0] dec_ex_imm,
  output logic        dec_ex_we,
  output logic        dec_ex_illegal
);

  op_t         op_s;
  imm_fmt_t    fmt_s;
  logic [31:0] imm_s;
  dec_bundle_t dec_s;
  dec_bundle_t bubble_s;
  dec_bundle_t bundle_r;

  // Classify the opcode and pick its immediate layout.
  always_comb begin
    op_s  = OP_ILLEGAL;
    fmt_s = IMM_NONE;
    if (fetch_dec_instr[1:0] != 2'b11) begin
      op_s  = OP_ILLEGAL;
      fmt_s = IMM_NONE;
    end else begin
      case (fetch_dec_instr[6:0])
        OPC_LUI:    begin op_s = OP_LUI;     fmt_s = IMM_U;    end
        OPC_AUIPC:  begin op_s = OP_AUIPC;   fmt_s = IMM_U;    end
        OPC_JAL:    begin op_s = OP_JAL;     fmt_s = IMM_J;    end
        OPC_JALR:   begin op_s = OP_JALR;    fmt_s = IMM_I;    end
        OPC_BRANCH: begin op_s = OP_BRANCH;  fmt_s = IMM_B;    end
        OPC_LOAD:   begin op_s = OP_LOAD;    fmt_s = IMM_I;    end
        OPC_STORE:  begin op_s = OP_STORE;   fmt_s = IMM_S;    end
        OPC_OPIMM:  begin op_s = OP_OPIMM;   fmt_s = IMM_I;    end
        OPC_OP:     begin op_s = OP_OP;      fmt_s = IMM_NONE; end
        OPC_FENCE:  begin op_s = OP_FENCE;   fmt_s = IMM_NONE; end
        OPC_SYSTEM: begin op_s = OP_SYSTEM;  fmt_s = IMM_NONE; end
        default:    begin op_s = OP_ILLEGAL; fmt_s = IMM_NONE; end
      endcase
    end
  end

  imm_gen u_imm_gen (
    .instr (fetch_dec_instr),
    .fmt   (fmt_s),
    .imm   (imm_s)
  );

  // Assemble the decoded bundle for a real instruction.
  always_comb begin
    dec_s          = '0;
    dec_s.valid    = 1'b1;
    dec_s.instr    = fetch_dec_instr;
    dec_s.pc       = fetch_dec_pc;
    dec_s.op       = op_s;
    dec_s.rd       = fetch_dec_instr[11:7];
    dec_s.rs1      = fetch_dec_instr[19:15];
    dec_s.rs2      = fetch_dec_instr[24:20];
    dec_s.funct3   = fetch_dec_instr[14:12];
    dec_s.funct7b5 = fetch_dec_instr[30];
    dec_s.imm      = imm_s;
    // x0 writes are dropped here so execute never has to check rd.
    dec_s.we       = op_writes_rd(op_s) && (fetch_dec_instr[11:7] != 5'd0);
    dec_s.illegal  = (op_s == OP_ILLEGAL);
  end

  // Bubble: every field cleared so nothing stale survives a kill.
  always_comb begin
    bubble_s       = '0;
    bubble_s.instr = NOP_INSTR;
    bubble_s.op    = OP_OPIMM;
  end

  // Pipeline register; priority rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_r <= bubble_s;
    end else if (flush) begin
      bundle_r <= bubble_s;
    end else if (stall) begin
      bundle_r <= bundle_r;
    end else if (fetch_dec_valid) begin
      bundle_r <= dec_s;
    end else begin
      bundle_r <= bubble_s;
    end
  end

  assign dec_ex_valid    = bundle_r.valid;
  assign dec_ex_instr    = bundle_r.instr;
  assign dec_ex_pc       = bundle_r.pc;
  assign dec_ex_op       = bundle_r.op;
  assign dec_ex_rd       = bundle_r.rd;
  assign dec_ex_rs1      = bundle_r.rs1;
  assign dec_ex_rs2      = bundle_r.rs2;
  assign dec_ex_funct3   = bundle_r.funct3;
  assign dec_ex_funct7b5 = bundle_r.funct7b5;
  assign dec_ex_imm      = bundle_r.imm;
  assign dec_ex_we       = bundle_r.we;
  assign dec_ex_illegal  = bundle_r.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: a table of single-cycle decode vectors
// plus hand-written reset, stall and flush sequences.
module tb_decode;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        stall;
  logic        flush;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  op_t         d_op;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [2:0]  d_f3;
  logic        d_f7;
  logic [31:0] d_imm;
  logic        d_we;
  logic        d_ill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_dec_instr (f_instr),
    .fetch_dec_pc    (f_pc),
    .fetch_dec_valid (f_valid),
    .stall           (stall),
    .flush           (flush),
    .dec_ex_valid    (d_valid),
    .dec_ex_instr    (d_instr),
    .dec_ex_pc       (d_pc),
    .dec_ex_op       (d_op),
    .dec_ex_rd       (d_rd),
    .dec_ex_rs1      (d_rs1),
    .dec_ex_rs2      (d_rs2),
    .dec_ex_funct3   (d_f3),
    .dec_ex_funct7b5 (d_f7),
    .dec_ex_imm      (d_imm),
    .dec_ex_we       (d_we),
    .dec_ex_illegal  (d_ill)
  );

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fv;
    exp_t        e;
  } vec_t;

  function automatic exp_t mk(input logic v, input logic [31:0] i,
                              input logic [31:0] p, input op_t op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic f7, input logic [31:0] imm,
                              input logic we, input logic ill);
    exp_t e;
    e.valid = v; e.instr = i; e.pc = p; e.op = op;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7;
    e.imm = imm; e.we = we; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(1'b0, 32'h0000_0013, 32'd0, OP_OPIMM, 5'd0, 5'd0, 5'd0,
              3'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(d_valid), 32'(e.valid));
    chk({tag, ".instr"}, d_instr, e.instr);
    chk({tag, ".pc"}, d_pc, e.pc);
    chk({tag, ".op"}, 32'(d_op), 32'(e.op));
    chk({tag, ".rd"}, 32'(d_rd), 32'(e.rd));
    chk({tag, ".rs1"}, 32'(d_rs1), 32'(e.rs1));
    chk({tag, ".rs2"}, 32'(d_rs2), 32'(e.rs2));
    chk({tag, ".funct3"}, 32'(d_f3), 32'(e.f3));
    chk({tag, ".funct7b5"}, 32'(d_f7), 32'(e.f7));
    chk({tag, ".imm"}, d_imm, e.imm);
    chk({tag, ".we"}, 32'(d_we), 32'(e.we));
    chk({tag, ".illegal"}, 32'(d_ill), 32'(e.ill));
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic cycle(input logic r, input logic s, input logic f,
                       input logic [31:0] i, input logic [31:0] p,
                       input logic v);
    rst = r; stall = s; flush = f; f_instr = i; f_pc = p; f_valid = v;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];
  exp_t ea;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    f_instr = 32'h0; f_pc = 32'h0; f_valid = 1'b0;

    // Reset overrides stall and a valid fetch.
    cycle(1'b1, 1'b1, 1'b0, 32'hFFF0_0093, 32'd3, 1'b1);
    chk_all("reset", bubble());

    vecs[0]  = '{32'hFFF0_0093, 32'd5, 1'b1, mk(1'b1, 32'hFFF0_0093, 32'd5, OP_OPIMM,
                 5'd1, 5'd0, 5'd31, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0)};
    vecs[1]  = '{32'hFE00_0EE3, 32'd7, 1'b1, mk(1'b1, 32'hFE00_0EE3, 32'd7, OP_BRANCH,
                 5'd29, 5'd0, 5'd0, 3'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0)};
    vecs[2]  = '{32'h8000_006F, 32'd9, 1'b1, mk(1'b1, 32'h8000_006F, 32'd9, OP_JAL,
                 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF0_0000, 1'b0, 1'b0)};
    vecs[3]  = '{32'h1234_52B7, 32'd10, 1'b1, mk(1'b1, 32'h1234_52B7, 32'd10, OP_LUI,
                 5'd5, 5'd8, 5'd3, 3'd5, 1'b0, 32'h1234_5000, 1'b1, 1'b0)};
    vecs[4]  = '{32'hFE21_AE23, 32'd11, 1'b1, mk(1'b1, 32'hFE21_AE23, 32'd11, OP_STORE,
                 5'd28, 5'd3, 5'd2, 3'd2, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0)};
    vecs[5]  = '{32'h0020_81B3, 32'd12, 1'b1, mk(1'b1, 32'h0020_81B3, 32'd12, OP_OP,
                 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 1'b0)};
    vecs[6]  = '{32'h0000_0000, 32'd13, 1'b1, mk(1'b1, 32'h0000_0000, 32'd13, OP_ILLEGAL,
                 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1)};
    vecs[7]  = '{32'h1234_52B7, 32'd99, 1'b0, bubble()};
    vecs[8]  = '{32'h0000_2003, 32'd14, 1'b1, mk(1'b1, 32'h0000_2003, 32'd14, OP_LOAD,
                 5'd0, 5'd0, 5'd0, 3'd2, 1'b0, 32'd0, 1'b0, 1'b0)};
    vecs[9]  = '{32'h0081_00E7, 32'd15, 1'b1, mk(1'b1, 32'h0081_00E7, 32'd15, OP_JALR,
                 5'd1, 5'd2, 5'd8, 3'd0, 1'b0, 32'd8, 1'b1, 1'b0)};
    vecs[10] = '{32'h0000_0073, 32'd16, 1'b1, mk(1'b1, 32'h0000_0073, 32'd16, OP_SYSTEM,
                 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0)};
    vecs[11] = '{32'hFFF0_0091, 32'd17, 1'b1, mk(1'b1, 32'hFFF0_0091, 32'd17, OP_ILLEGAL,
                 5'd1, 5'd0, 5'd31, 3'd0, 1'b1, 32'd0, 1'b0, 1'b1)};

    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b0, 1'b0, vecs[k].instr, vecs[k].pc, vecs[k].fv);
      chk_all($sformatf("vec%0d", k), vecs[k].e);
    end

    // Stall holds A for 3 cycles while fetch inputs change.
    ea = vecs[3].e;
    cycle(1'b0, 1'b0, 1'b0, vecs[3].instr, vecs[3].pc, 1'b1);
    chk_all("load_a", ea);
    cycle(1'b0, 1'b1, 1'b0, 32'hFFF0_0093, 32'd40, 1'b1);
    chk_all("stall1", ea);
    cycle(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd41, 1'b0);
    chk_all("stall2", ea);
    cycle(1'b0, 1'b1, 1'b0, 32'h0020_81B3, 32'd42, 1'b1);
    chk_all("stall3", ea);

    // Flush wins over stall, and over a valid fetch.
    cycle(1'b0, 1'b1, 1'b1, 32'h0020_81B3, 32'd43, 1'b1);
    chk_all("stall_flush", bubble());
    cycle(1'b0, 1'b0, 1'b0, vecs[0].instr, vecs[0].pc, 1'b1);
    chk_all("reload", vecs[0].e);
    cycle(1'b0, 1'b0, 1'b1, 32'h0020_81B3, 32'd44, 1'b1);
    chk_all("flush_valid", bubble());

    // Reset during a stall ends the hold; the next cycle loads normally.
    cycle(1'b0, 1'b0, 1'b0, vecs[9].instr, vecs[9].pc, 1'b1);
    chk_all("pre_rst", vecs[9].e);
    cycle(1'b1, 1'b1, 1'b0, vecs[9].instr, vecs[9].pc, 1'b1);
    chk_all("rst_in_stall", bubble());
    cycle(1'b0, 1'b0, 1'b0, vecs[5].instr, vecs[5].pc, 1'b1);
    chk_all("post_rst_load", vecs[5].e);
    cycle(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd50, 1'b1);
    chk_all("post_rst_hold", vecs[5].e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013, instruction word reported for bubbles (RV32I addi x0,x0,0).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 fetch_dec_instr  input  32  instruction word from the fetch stage.
REQ-005 fetch_dec_pc  input  32  word-addressed PC+1 value from the fetch stage.
REQ-006 fetch_dec_valid  input  1  fetch outputs carry a real instruction this cycle.
REQ-007 stall  input  1  hazard unit hold request: keep the current output register.
REQ-008 flush  input  1  branch-redirect kill: replace the current output register with a bubble.
REQ-009 dec_ex_valid  output  1  decoded bundle is a real instruction.
REQ-010 dec_ex_instr  output  32  raw instruction word (NOP_INSTR when a bubble).
REQ-011 dec_ex_pc  output  32  fetch_dec_pc captured with the instruction.
REQ-012 dec_ex_op  output  4  opcode class enum from the shared package.
REQ-013 dec_ex_rd, dec_ex_rs1, dec_ex_rs2  output  5 each  register indices.
REQ-014 dec_ex_funct3  output  3; dec_ex_funct7b5  output  1 (instr[30]).
REQ-015 dec_ex_imm  output  32  sign-extended immediate, byte offset.
REQ-016 dec_ex_we  output  1  instruction writes rd, and rd != 0.
REQ-017 dec_ex_illegal  output  1  opcode not in RV32I base set.

Function
REQ-018 The stage is one pipeline register: decode is combinational from fetch_dec_*; results are registered; latency 1 cycle.
REQ-019 Op classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, ILLEGAL; decoded from instr[6:0].
REQ-020 Immediate formats: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended from instr[31]; OP/FENCE/SYSTEM/ILLEGAL yield 0.
REQ-021 dec_ex_we is 1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP when rd != 0; otherwise 0.
REQ-022 Illegal instruction: any opcode outside REQ-019, or instr[1:0] != 2'b11; it propagates with dec_ex_valid=1, dec_ex_illegal=1, dec_ex_we=0.
REQ-023 Priority per cycle: rst > flush > stall > load.
REQ-024 flush=1: next cycle outputs a bubble regardless of stall or fetch_dec_valid.
REQ-025 stall=1, flush=0: every output holds its value; fetch inputs are ignored.
REQ-026 Load (neither asserted): if fetch_dec_valid=1, capture the decoded bundle with valid=1; else capture a bubble.
REQ-027 Bubble definition: valid=0, instr=NOP_INSTR, op=OPIMM, all indices 0, imm 0, we=0, illegal=0, pc=0.
REQ-028 No field of a bubble may carry stale data from a prior instruction.

Reset
REQ-029 rst=1 at a rising edge forces a bubble into the output register (REQ-027), overriding stall and flush.
REQ-030 Reset asserted mid-stall ends the hold; the first post-reset cycle loads normally.

Structure
REQ-031 Op-class enum, opcode constants, and NOP_INSTR default value belong in the shared CPU package.
REQ-032 One sub-module, imm_gen (combinational immediate extraction per REQ-020), is natural; the rest stays in decode.

Verification
REQ-033 Reset: rst=1 with stall=1 and fetch_dec_valid=1 -> next cycle valid=0, instr=32'h0000_0013, we=0.
REQ-034 Decode: instr=32'hFFF0_0093 (addi x1,x0,-1), pc=5, valid=1 -> next cycle op=OPIMM, rd=1, rs1=0, imm=32'hFFFF_FFFF, we=1, pc=5.
REQ-035 Immediates: B-type 32'hFE00_0EE3 -> imm=32'hFFFF_FFFC; J-type 32'h8000_006F -> imm=32'hFFF0_0000, rd=0, we=0.
REQ-036 Stall/flush: load instr A, hold stall=1 for 3 cycles while inputs change -> outputs equal A throughout; assert stall=1 and flush=1 together -> bubble.
REQ-037 Illegal/bubble: instr=32'h0000_0000, valid=1 -> illegal=1, valid=1, we=0; then fetch_dec_valid=0 -> bubble with pc=0.
